dpram_sclk: RTL and testbench

//   Single-clock simple dual-port RAM: one write port, one read port, both

---
 rtl/dpram_sclk.sv | 38 +++
 tb/tb_dpram_sclk.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dpram_sclk.sv
// Single-clock simple dual-port RAM: independent write and read ports, one-cycle
// registered read with write-first forwarding; only the output register is reset.
module dpram_sclk #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DEPTH      = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  same_addr_wr;

    assign same_addr_wr = we && (waddr == raddr);

    // Array kept reset-free so it maps onto block RAM; rst only gates the write.
    always_ff @(posedge clk) begin
        if (rst && we) begin
            mem[waddr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= '0;
        end else if (re) begin
            dout <= same_addr_wr ? din : mem[raddr];
        end
    end

endmodule

// File: tb/tb_dpram_sclk.sv
// Randomized self-checking bench for dpram_sclk against an array-based RAM model.
module tb_dpram_sclk;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 9;
    localparam int unsigned DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [AW-1:0] raddr = '0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] ref_mem   [DEPTH];
    bit            ref_valid [DEPTH];
    logic [DW-1:0] exp_dout  = '0;
    bit            exp_known = 1'b0;

    dpram_sclk #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .re   (re),
        .waddr(waddr),
        .raddr(raddr),
        .din  (din),
        .dout (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: dout=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare.
    task automatic step(input string tag);
        @(posedge clk);
        if (!rst) begin
            exp_dout  = '0;
            exp_known = 1'b1;
        end else begin
            if (re) begin
                if (we && waddr == raddr) begin
                    exp_dout  = din;
                    exp_known = 1'b1;
                end else begin
                    exp_dout  = ref_mem[raddr];
                    exp_known = ref_valid[raddr];
                end
            end
            if (we) begin
                ref_mem[waddr]   = din;
                ref_valid[waddr] = 1'b1;
            end
        end
        #1;
        if (exp_known) check(tag, dout, exp_dout);
    endtask

    task automatic idle();
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1; re = 1'b0; waddr = a; din = d;
        step("write");
    endtask

    task automatic read_word(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        we = 1'b0; re = 1'b1; raddr = a;
        step(tag);
        check({tag, "_abs"}, dout, exp);
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) ref_valid[i] = 1'b0;

        // Reset held with random enables; writes during reset must be dropped.
        #2 rst = 1'b0;
        #1 check("reset_async", dout, '0);
        for (int i = 0; i < 10; i++) begin
            we = 1'($urandom); re = 1'($urandom);
            waddr = AW'($urandom); raddr = AW'($urandom); din = DW'($urandom);
            step("reset_hold");
            check("reset_zero", dout, '0);
        end
        idle();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("post_reset_idle");
            check("post_reset_zero", dout, '0);
        end

        // Streaming write with read trailing by one cycle.
        for (int k = 0; k <= 150; k++) begin
            we = (k < 150); waddr = AW'(k); din = DW'(k);
            re = (k > 0);   raddr = AW'(k - 1);
            step("stream");
            if (k > 0) check("stream_abs", dout, DW'(k - 1));
        end
        idle();

        // Same-address read-during-write is write-first.
        we = 1'b1; re = 1'b1; waddr = 9'h005; raddr = 9'h005; din = 16'hBEEF;
        step("rdw_same");
        check("rdw_same_abs", dout, 16'hBEEF);
        idle();
        step("idle");
        read_word("rdw_later", 9'h005, 16'hBEEF);

        // Address extremes and overwrite.
        write_word(9'h1FF, 16'h1234);
        write_word(9'h000, 16'hAAAA);
        read_word("top_addr", 9'h1FF, 16'h1234);
        read_word("wrap_addr", 9'h000, 16'hAAAA);
        write_word(9'h000, 16'h5555);
        read_word("overwrite", 9'h000, 16'h5555);

        // re low holds dout while raddr moves.
        write_word(9'h020, 16'h0007);
        read_word("pre_hold", 9'h020, 16'h0007);
        for (int i = 0; i < 5; i++) begin
            we = 1'b0; re = 1'b0; raddr = AW'($urandom);
            step("hold");
            check("hold_abs", dout, 16'h0007);
        end

        // Reset pulse between edges clears dout, keeps memory, drops a write on the reset edge.
        write_word(9'h010, 16'h00A5);
        read_word("pre_pulse", 9'h010, 16'h00A5);
        idle();
        rst = 1'b0;
        #1 check("pulse_async", dout, '0);
        exp_dout = '0; exp_known = 1'b1;
        #1 rst = 1'b1;
        step("pulse_idle");
        we = 1'b1; waddr = 9'h010; din = 16'hDEAD;
        rst = 1'b0;
        step("reset_edge_write");
        rst = 1'b1;
        idle();
        read_word("retained", 9'h010, 16'h00A5);

        // Random traffic on a narrow address window to exercise collisions.
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom); re = 1'($urandom);
            waddr = AW'($urandom_range(0, 15)); raddr = AW'($urandom_range(0, 15));
            din = DW'($urandom);
            step("random");
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
